pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
Receive-side counterpart of the RGB PWM fade generator. Samples the three PWM LED drive lines (RGB_R/G/B as produced by top) and recovers each channel's duty as an active-cycle count per PWM interval. Used as a bench/checker block and as an on-chip loopback monitor, with a valid strobe and a per-channel stuck-level flag.

Parameters:
PWM_INTERVAL, 1250, PWM period in clk cycles; also the measurement window length.
ACTIVE_LOW, 1, 1 = line low means LED on (counted as active); 0 = high is active.
SYNC_STAGES, 2, synchronizer flops per input (>=2).
CNT_W, $clog2(PWM_INTERVAL+1), duty count width; 11 at default.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
pwm_r  input  1  red PWM line (asynchronous to clk allowed)
pwm_g  input  1  green PWM line
pwm_b  input  1  blue PWM line
duty_r  output  CNT_W  active cycles of red in last complete window
duty_g  output  CNT_W  same, green
duty_b  output  CNT_W  same, blue
stuck_r  output  1  red showed no edge in last window
stuck_g  output  1  same, green
stuck_b  output  1  same, blue
duty_valid  output  1  one-cycle strobe: duty_*/stuck_* updated this cycle
window_idx  output  16  count of completed windows, wraps at 65535->0

Behaviour:
- Reset is asynchronous and active-low; clock is clk. On rst_n=0: all outputs 0; synchronizer flops and previous-sample flops load the inactive level (1 if ACTIVE_LOW, else 0); window_cnt=0; accumulators=0; edge-seen flags=0.
- Input path: each line passes through SYNC_STAGES flops. act_x = sync_x XOR ACTIVE_LOW. Input-to-count latency = SYNC_STAGES cycles.
- window_cnt runs 0..PWM_INTERVAL-1, then wraps to 0. It is free-running and not phase-locked to the source. A full window of a constant-duty source still yields the exact duty.
- Each cycle: acc_x += act_x. edge_x = sync_x != prev_x. seen_x |= edge_x.
- At window_cnt == PWM_INTERVAL-1 (terminal cycle), registered, visible the next cycle:
  - duty_x <= acc_x + act_x; stuck_x <= ~(seen_x | edge_x).
  - acc_x <= 0; seen_x <= 0.
  - duty_valid <= 1 for exactly one cycle; window_idx <= window_idx + 1.
- Outputs hold between strobes.
- First strobe: window_cnt is 0 in the first clk after rst_n rises. duty_valid is high in cycle PWM_INTERVAL after that, counting that first cycle as cycle 0.
- Width rule: acc and duty saturate-free. Maximum value is PWM_INTERVAL, which fits CNT_W by construction.
- Boundary cases:
  - Always-active line: duty = PWM_INTERVAL, stuck = 1.
  - Always-inactive line: duty = 0, stuck = 1.
  - An edge in the terminal cycle counts toward the closing window only.
- Reset mid-window: the partial window is discarded, no strobe is emitted, and the first strobe after release follows the first-strobe rule.
- No other state machine. The window counter is the sole sequencer, so every window has exactly the same length.

Decomposition:
- Package pwm_pkg holds:
  - localparam PWM_INTERVAL_DEFAULT = 1250, shared with top.
  - function duty_width(interval), returning $clog2(interval+1).
  - typedef duty_t sized for the default.
- Sub-module pwm_chan_meter, instantiated 3x, contains:
  - the synchronizer, polarity fix, prev sample, accumulator and edge-seen flag;
  - inputs clk, rst_n, pwm_in, window_end;
  - outputs duty, stuck.
- pwm_capture owns window_cnt, duty_valid and window_idx.

Test Plan:
- Reset release, all lines held 1 (ACTIVE_LOW=1) -> first duty_valid exactly 1250 cycles after release; duty_r/g/b = 0; stuck_* = 1; window_idx = 1.
- pwm_r low for 625 cycles then high for 625, period 1250, repeating; run 3 windows -> every strobe after the first has duty_r = 625, stuck_r = 0; g/b unchanged at 0/stuck.
- pwm_g period 1250 with 1 low cycle; pwm_b with 1249 low cycles -> duty_g = 1, duty_b = 1249, both stuck = 0, independent of phase offset; sweep offsets 0, 1, 617, 1249.
- pwm_b held 0 continuously -> duty_b = 1250, stuck_b = 1, no overflow.
- Assert rst_n=0 at window_cnt=700 for 3 cycles, then release -> no strobe during or at the old window end; all outputs read 0 until the next strobe 1250 cycles after release.
- Instantiate top (PWM_INTERVAL=1250) driving this block and run a full fade -> every strobe's duty_x is within [0,1250]; between consecutive windows it changes by at most one fade step; duty_valid period is always 1250 cycles.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM capture block and its channel meters.
package pwm_pkg;

  // Default PWM period in clk cycles; also the measurement window length.
  localparam int PWM_INTERVAL_DEFAULT = 1250;

  // Width needed to hold a duty count in the range 0..interval inclusive.
  function automatic int duty_width(input int interval);
    return $clog2(interval + 1);
  endfunction

  localparam int DUTY_W_DEFAULT = $clog2(PWM_INTERVAL_DEFAULT + 1);

  // Duty count type sized for the default interval (11 bits at 1250).
  typedef logic [DUTY_W_DEFAULT-1:0] duty_t;

endpackage

// File: rtl/pwm_chan_meter.sv
// One PWM channel meter: synchronizes the line, normalizes polarity, counts
// active cycles and watches for edges within the current window. At the
// window's terminal cycle it publishes the count and the stuck-level flag.
module pwm_chan_meter
  import pwm_pkg::*;
#(
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = duty_width(PWM_INTERVAL_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             window_end,
  output logic [CNT_W-1:0] duty,
  output logic             stuck
);

  // Level the line rests at when the LED is off; flops reset to it so that
  // no spurious edge or active cycle is seen right after reset.
  localparam logic INACTIVE = ACTIVE_LOW;

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   prev_level;
  logic [CNT_W-1:0]       acc;
  logic                   seen;
  logic                   level;
  logic                   active;
  logic                   edge_now;

  assign level    = sync_pipe[SYNC_STAGES-1];
  assign active   = level ^ ACTIVE_LOW;
  assign edge_now = (level != prev_level);

  // Synchronizer chain bringing the asynchronous line into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe <= {SYNC_STAGES{INACTIVE}};
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], pwm_in};
    end
  end

  // Per-window accumulation of active cycles and edge detection; both
  // restart at the terminal cycle, whose own sample belongs to the closing window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_level <= INACTIVE;
      acc        <= '0;
      seen       <= 1'b0;
    end else begin
      prev_level <= level;
      if (window_end) begin
        acc  <= '0;
        seen <= 1'b0;
      end else begin
        acc  <= acc + CNT_W'(active);
        seen <= seen | edge_now;
      end
    end
  end

  // Result registers, loaded once per window and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty  <= '0;
      stuck <= 1'b0;
    end else begin
      if (window_end) begin
        duty  <= acc + CNT_W'(active);
        stuck <= ~(seen | edge_now);
      end else begin
        duty  <= duty;
        stuck <= stuck;
      end
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// Three-channel PWM duty capture. A free-running window counter is the only
// sequencer; every window is exactly PWM_INTERVAL cycles long, and each
// channel meter publishes its duty and stuck flag at the window's end.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int PWM_INTERVAL = PWM_INTERVAL_DEFAULT,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = duty_width(PWM_INTERVAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_r,
  input  logic             pwm_g,
  input  logic             pwm_b,
  output logic [CNT_W-1:0] duty_r,
  output logic [CNT_W-1:0] duty_g,
  output logic [CNT_W-1:0] duty_b,
  output logic             stuck_r,
  output logic             stuck_g,
  output logic             stuck_b,
  output logic             duty_valid,
  output logic [15:0]      window_idx
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PWM_INTERVAL - 1);

  logic [CNT_W-1:0] window_cnt;
  logic             window_end;

  assign window_end = (window_cnt == LAST_CNT);

  // Window counter: 0..PWM_INTERVAL-1, wrapping; not locked to the source phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_cnt <= '0;
    end else begin
      if (window_end) begin
        window_cnt <= '0;
      end else begin
        window_cnt <= window_cnt + CNT_W'(1);
      end
    end
  end

  // Result strobe and completed-window counter, aligned with the meter results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_valid <= 1'b0;
      window_idx <= 16'd0;
    end else begin
      duty_valid <= window_end;
      if (window_end) begin
        window_idx <= window_idx + 16'd1;
      end else begin
        window_idx <= window_idx;
      end
    end
  end

  pwm_chan_meter #(
    .ACTIVE_LOW (ACTIVE_LOW),
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) u_meter_r (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_r),
    .window_end(window_end),
    .duty      (duty_r),
    .stuck     (stuck_r)
  );

  pwm_chan_meter #(
    .ACTIVE_LOW (ACTIVE_LOW),
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) u_meter_g (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_g),
    .window_end(window_end),
    .duty      (duty_g),
    .stuck     (stuck_g)
  );

  pwm_chan_meter #(
    .ACTIVE_LOW (ACTIVE_LOW),
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) u_meter_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_b),
    .window_end(window_end),
    .duty      (duty_b),
    .stuck     (stuck_b)
  );

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture at default parameters (1250-cycle window,
// active-low lines, two synchronizer stages).
module tb_pwm_capture;

  localparam int P = 1250;
  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pwm_r, pwm_g, pwm_b;
  logic [W-1:0] duty_r, duty_g, duty_b;
  logic         stuck_r, stuck_g, stuck_b;
  logic         duty_valid;
  logic [15:0]  window_idx;

  typedef struct packed {
    logic [W-1:0] dr;
    logic [W-1:0] dg;
    logic [W-1:0] db;
    logic         sr;
    logic         sg;
    logic         sb;
    logic [15:0]  idx;
  } res_t;

  res_t exp_q[$];
  res_t held;

  int total = 0;
  int bad   = 0;

  // Stimulus pattern per channel: active while ((g + off) mod P) < lo.
  int lo [3];
  int off[3];
  int g;
  // Reference model: line activity two and three cycles back, window sums.
  int           n;
  logic [15:0]  midx;
  logic         a1 [3];
  logic         a2 [3];
  logic         a3 [3];
  logic [W-1:0] acc [3];
  logic         seen[3];

  always #5 clk = ~clk;

  pwm_capture dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_r     (pwm_r),
    .pwm_g     (pwm_g),
    .pwm_b     (pwm_b),
    .duty_r    (duty_r),
    .duty_g    (duty_g),
    .duty_b    (duty_b),
    .stuck_r   (stuck_r),
    .stuck_g   (stuck_g),
    .stuck_b   (stuck_b),
    .duty_valid(duty_valid),
    .window_idx(window_idx)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, n);
    end
  endtask

  // One clock cycle: compare DUT outputs at the falling edge, then apply
  // reset/stimulus for the coming rising edge and advance the model.
  task automatic step(input logic rst_in);
    logic act[3];
    res_t e;
    res_t got;
    @(negedge clk);
    g++;
    got = {duty_r, duty_g, duty_b, stuck_r, stuck_g, stuck_b, window_idx};
    if (rst_n && n > 0 && (n % P) == 0) begin
      check_val("strobe", 64'(duty_valid), 64'd1);
      check_val("sb_depth", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_val("duty_r", 64'(duty_r), 64'(e.dr));
        check_val("duty_g", 64'(duty_g), 64'(e.dg));
        check_val("duty_b", 64'(duty_b), 64'(e.db));
        check_val("stuck_rgb", 64'({stuck_r, stuck_g, stuck_b}), 64'({e.sr, e.sg, e.sb}));
        check_val("window_idx", 64'(window_idx), 64'(e.idx));
        held = e;
      end
    end else begin
      check_val("no_strobe", 64'(duty_valid), 64'd0);
    end
    check_val("hold", 64'(got), 64'(held));

    if (!rst_in) begin
      rst_n = 1'b0;
      n     = 0;
      midx  = 16'd0;
      held  = '0;
      exp_q.delete();
      for (int c = 0; c < 3; c++) begin
        a1[c] = 1'b0; a2[c] = 1'b0; a3[c] = 1'b0;
        acc[c] = '0;  seen[c] = 1'b0;
      end
    end else begin
      rst_n = 1'b1;
    end

    for (int c = 0; c < 3; c++) act[c] = (((g + off[c]) % P) < lo[c]);
    pwm_r = ~act[0];
    pwm_g = ~act[1];
    pwm_b = ~act[2];

    if (rst_n) begin
      for (int c = 0; c < 3; c++) begin
        acc[c] = acc[c] + W'(a2[c]);
        if (a2[c] != a3[c]) seen[c] = 1'b1;
      end
      if ((n % P) == P - 1) begin
        midx  = midx + 16'd1;
        e.dr  = acc[0]; e.dg = acc[1]; e.db = acc[2];
        e.sr  = ~seen[0]; e.sg = ~seen[1]; e.sb = ~seen[2];
        e.idx = midx;
        exp_q.push_back(e);
        for (int c = 0; c < 3; c++) begin
          acc[c] = '0; seen[c] = 1'b0;
        end
      end
      for (int c = 0; c < 3; c++) begin
        a3[c] = a2[c]; a2[c] = a1[c]; a1[c] = act[c];
      end
      n++;
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1);
  endtask

  initial begin
    int offs[4];
    offs = '{0, 1, 617, 1249};
    g = 0; n = 0; midx = 16'd0; held = '0;
    for (int c = 0; c < 3; c++) begin
      lo[c] = 0; off[c] = 0;
      a1[c] = 1'b0; a2[c] = 1'b0; a3[c] = 1'b0;
      acc[c] = '0; seen[c] = 1'b0;
    end
    rst_n = 1'b0;
    pwm_r = 1'b1; pwm_g = 1'b1; pwm_b = 1'b1;

    // All lines idle: first strobe 1250 cycles after release, duty 0, stuck.
    repeat (3) step(1'b0);
    run(2 * P);

    // Red 50% square wave.
    lo[0] = 625;
    run(3 * P);

    // Green one active cycle, blue 1249, at several phase offsets.
    lo[1] = 1;
    lo[2] = P - 1;
    for (int k = 0; k < 4; k++) begin
      off[1] = offs[k];
      off[2] = offs[k];
      run(2 * P);
    end

    // Blue held low continuously: full-scale duty, stuck.
    lo[2] = P;
    run(2 * P);

    // Reset in the middle of a window at window_cnt = 700.
    while ((n % P) != 700) step(1'b1);
    repeat (3) step(1'b0);
    run(2 * P + 2);

    // Stepwise fade on red, one step per window.
    for (int k = 0; k < 5; k++) begin
      lo[0] = k * 250;
      run(P);
    end
    run(P + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
